// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates fetch and data requests onto one single-ported RAM
// Data accesses win over fetches; a watchdog aborts accesses the RAM never completes.
module mem_arbiter #(
  parameter int          TIMEOUT = 255,
  parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        memerr,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic        ramready,
  input  logic [31:0] ramload
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, IACC, DACC, IRESP, DRESP} state_t;

  state_t      state, next_state;
  logic [7:0]  cnt_q;
  logic [31:0] addr_q, store_q, iload_q, dload_q;
  logic        rd_q, wr_q, err_q;
  logic        data_req, in_acc, timeout;

  assign data_req = dmemREN | dmemWEN;
  assign in_acc   = (state == IACC) || (state == DACC);
  assign timeout  = in_acc && (cnt_q == TMO) && !ramready;
  assign imemload = iload_q;
  assign dmemload = dload_q;

  always_comb begin
    next_state = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = 32'd0;
    ramstore   = 32'd0;
    ihit       = 1'b0;
    dhit       = 1'b0;
    memerr     = 1'b0;
    case (state)
      IDLE: begin
        if (data_req)     next_state = DACC;
        else if (imemREN) next_state = IACC;
      end
      IACC: begin
        ramREN  = 1'b1;
        ramaddr = addr_q;
        if (ramready || timeout) next_state = IRESP;
      end
      DACC: begin
        ramREN   = rd_q;
        ramWEN   = wr_q;
        ramaddr  = addr_q;
        ramstore = store_q;
        if (ramready || timeout) next_state = DRESP;
      end
      IRESP: begin
        ihit       = 1'b1;
        memerr     = err_q;
        next_state = IDLE;
      end
      DRESP: begin
        dhit       = 1'b1;
        memerr     = err_q;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= 32'd0;
      store_q <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      iload_q <= 32'd0;
      dload_q <= 32'd0;
    end else begin
      state <= next_state;
      if (state == IDLE) begin
        cnt_q <= 8'd0;
        err_q <= 1'b0;
        // A simultaneous read and write request is served as a write.
        if (data_req) begin
          addr_q  <= dmemaddr;
          store_q <= dmemstore;
          wr_q    <= dmemWEN;
          rd_q    <= dmemREN & ~dmemWEN;
        end else if (imemREN) begin
          addr_q  <= imemaddr;
          store_q <= 32'd0;
          wr_q    <= 1'b0;
          rd_q    <= 1'b1;
        end
      end else if (in_acc) begin
        if (ramready) begin
          if (state == IACC) iload_q <= ramload;
          else if (rd_q)     dload_q <= ramload;
        end else if (timeout) begin
          err_q <= 1'b1;
          if (state == IACC) iload_q <= ERRWORD;
          else if (rd_q)     dload_q <= ERRWORD;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
// Expected behaviour comes from a transaction-level model of latency, priority and timeout.
module tb_mem_arbiter;

  localparam int          TMO = 4;
  localparam logic [31:0] ERR = 32'hBAD1BAD1;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN, dmemREN, dmemWEN, ramready;
  logic [31:0] imemaddr, dmemaddr, dmemstore, ramload;
  logic        ihit, dhit, memerr, ramREN, ramWEN;
  logic [31:0] imemload, dmemload, ramaddr, ramstore;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] exp_iload, exp_dload;

  mem_arbiter #(.TIMEOUT(TMO), .ERRWORD(ERR)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload), .memerr(memerr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramready(ramready), .ramload(ramload)
  );

  always #5 CLK = ~CLK;

  // One complete access: starts at a negedge with the arbiter idle, ends at a negedge back in IDLE.
  // delay = ACC cycle (1-based) carrying ramready; 0 means the RAM never answers.
  task automatic do_access(input bit is_data, input bit wr, input bit rd,
                           input logic [31:0] addr, input logic [31:0] store,
                           input int delay, input logic [31:0] rdata,
                           input bit hold_fetch, input string tag);
    bit          err, is_read, exp_ren, exp_wen;
    int          n_acc;
    logic [31:0] exp_st;
    is_read = !is_data || !wr;
    err     = !(delay >= 1 && delay <= TMO + 1);
    n_acc   = err ? TMO + 1 : delay;
    exp_ren = is_data ? (rd && !wr) : 1'b1;
    exp_wen = is_data ? wr : 1'b0;
    exp_st  = store;
    if (is_data) begin
      dmemREN = rd; dmemWEN = wr; dmemaddr = addr; dmemstore = store;
    end else begin
      imemREN = 1'b1; imemaddr = addr;
    end
    for (int i = 1; i <= n_acc; i++) begin
      @(negedge CLK);
      checks++;
      if ({ramREN, ramWEN, ramaddr, ihit, dhit, memerr} !== {exp_ren, exp_wen, addr, 3'b000}) begin
        $display("FAIL %s acc%0d cmd: got ren=%b wen=%b addr=%h hits=%b%b%b, want ren=%b wen=%b addr=%h hits=000",
                 tag, i, ramREN, ramWEN, ramaddr, ihit, dhit, memerr, exp_ren, exp_wen, addr);
      end else passes++;
      if (is_data) begin
        checks++;
        if (ramstore !== exp_st)
          $display("FAIL %s acc%0d ramstore: got %h want %h", tag, i, ramstore, exp_st);
        else passes++;
      end
      dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = $urandom; dmemstore = $urandom;
      if (!hold_fetch) begin imemREN = 1'b0; imemaddr = $urandom; end
      ramready = (i == delay);
      ramload  = (i == delay) ? rdata : $urandom;
    end
    @(negedge CLK);
    ramready = 1'b0;
    if (is_read) begin
      if (is_data) exp_dload = err ? ERR : rdata;
      else         exp_iload = err ? ERR : rdata;
    end
    checks++;
    if ({ihit, dhit, memerr} !== {!is_data, is_data, err})
      $display("FAIL %s resp hits: got ihit=%b dhit=%b memerr=%b want %b %b %b",
               tag, ihit, dhit, memerr, !is_data, is_data, err);
    else passes++;
    checks++;
    if ({imemload, dmemload} !== {exp_iload, exp_dload})
      $display("FAIL %s resp loads: got i=%h d=%h want i=%h d=%h",
               tag, imemload, dmemload, exp_iload, exp_dload);
    else passes++;
    @(negedge CLK);
    checks++;
    if ({ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, memerr} !== '0 ||
        {imemload, dmemload} !== {exp_iload, exp_dload})
      $display("FAIL %s idle: got ren=%b wen=%b addr=%h st=%h hits=%b%b%b i=%h d=%h want zeros i=%h d=%h",
               tag, ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, memerr,
               imemload, dmemload, exp_iload, exp_dload);
    else passes++;
  endtask

  task automatic test_reset();
    nRST = 1'b0; imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; ramready = 1'b0;
    imemaddr = 32'd0; dmemaddr = 32'd0; dmemstore = 32'd0; ramload = 32'd0;
    exp_iload = 32'd0; exp_dload = 32'd0;
    #1;
    checks++;
    if ({ihit, dhit, memerr, ramREN, ramWEN, ramaddr, ramstore, imemload, dmemload} !== '0)
      $display("FAIL reset: got hits=%b%b%b ren=%b wen=%b addr=%h st=%h i=%h d=%h want all zero",
               ihit, dhit, memerr, ramREN, ramWEN, ramaddr, ramstore, imemload, dmemload);
    else passes++;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_fetch();
    do_access(1'b0, 1'b0, 1'b1, 32'h40, 32'd0, 3, 32'h8C010004, 1'b0, "fetch");
  endtask

  task automatic test_priority();
    imemREN = 1'b1; imemaddr = 32'h80;
    do_access(1'b1, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 2, 32'h0, 1'b1, "prio_data");
    do_access(1'b0, 1'b0, 1'b1, 32'h80, 32'd0, 1, 32'h12345678, 1'b0, "prio_fetch");
  endtask

  task automatic test_timeout();
    do_access(1'b1, 1'b0, 1'b1, 32'h200, 32'h5, 0, 32'h0, 1'b0, "timeout_dread");
    do_access(1'b0, 1'b0, 1'b1, 32'h204, 32'h0, 0, 32'h0, 1'b0, "timeout_fetch");
    do_access(1'b1, 1'b1, 1'b0, 32'h208, 32'h77, 0, 32'h0, 1'b0, "timeout_write");
  endtask

  task automatic test_timeout_edge();
    do_access(1'b1, 1'b0, 1'b1, 32'h300, 32'h0, TMO, 32'hCAFEF00D, 1'b0, "ready_at_T");
    do_access(1'b1, 1'b0, 1'b1, 32'h304, 32'h0, TMO + 1, 32'h0BADF00D, 1'b0, "ready_at_count_T");
  endtask

  task automatic test_drop();
    do_access(1'b1, 1'b0, 1'b1, 32'h400, 32'h0, 2, 32'hA5A5_5A5A, 1'b0, "drop");
  endtask

  task automatic test_reset_mid();
    dmemREN = 1'b1; dmemaddr = 32'h500;
    repeat (2) @(negedge CLK);
    dmemREN = 1'b0;
    nRST = 1'b0;
    exp_iload = 32'd0; exp_dload = 32'd0;
    #1;
    checks++;
    if ({ihit, dhit, memerr, ramREN, ramWEN, ramaddr, ramstore, imemload, dmemload} !== '0)
      $display("FAIL reset_mid: got hits=%b%b%b ren=%b wen=%b addr=%h i=%h d=%h want all zero",
               ihit, dhit, memerr, ramREN, ramWEN, ramaddr, imemload, dmemload);
    else passes++;
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      checks++;
      if ({ihit, dhit, memerr, ramREN, ramWEN} !== 5'b0)
        $display("FAIL reset_mid_quiet%0d: got hits=%b%b%b ren=%b wen=%b want 0",
                 i, ihit, dhit, memerr, ramREN, ramWEN);
      else passes++;
    end
    do_access(1'b0, 1'b0, 1'b1, 32'h504, 32'd0, 2, 32'h600DF00D, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      int kind;
      bit is_data;
      is_data = 1'($urandom_range(0, 1));
      kind    = $urandom_range(0, 2);
      do_access(is_data, is_data && kind != 0, !is_data || kind != 1,
                $urandom, $urandom, $urandom_range(0, 7), $urandom, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_timeout();
    test_timeout_edge();
    test_drop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
